nines_comp: RTL and testbench
=============================

NINES_COMP -- requirements
Module: nines_comp

Interface
REQ-001 Parameter: DIGITS, 1, number of 4-bit BCD digits processed in parallel (legal range 1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: B  input  4*DIGITS  BCD operand; digit i occupies bits [4i+3:4i].
REQ-005 Port: M  input  1  mode select: 1 = nine's complement, 0 = pass-through.
REQ-006 Port: in_valid  input  1  B and M are sampled only when high.
REQ-007 Port: Bcomp  output  4*DIGITS  registered result, digit-aligned with B.
REQ-008 Port: out_valid  output  1  high for one cycle per accepted input.
REQ-009 Port: err  output  1  registered flag; set when any accepted digit of B exceeds 9.

Function
REQ-010 Latency SHALL be exactly 1 cycle: an input accepted on edge N SHALL appear on Bcomp/out_valid/err after edge N.
REQ-011 With M=1, each result digit SHALL equal 9 minus the input digit, for input digits 0..9 (0->9, 1->8, ..., 9->0).
REQ-012 With M=0, each result digit SHALL equal the input digit unchanged, including non-BCD values 10..15.
REQ-013 With M=1 and an input digit of 10..15, that result digit SHALL be 0; all other digits are still complemented normally.
REQ-014 err SHALL be the OR, over all digits, of (digit > 9), independent of M, registered with the same latency as Bcomp.
REQ-015 The digit function SHALL be combinational and identical for every digit; there is no carry or interaction between digits.
REQ-016 When in_valid=0 on an edge, Bcomp and err SHALL hold their previous values and out_valid SHALL be 0 after that edge.
REQ-017 Back-to-back accepted inputs SHALL be supported at full rate: one result per cycle with no bubbles.
REQ-018 M SHALL be sampled together with B on the accepting edge; changing M between accepts SHALL affect only subsequent results.
REQ-019 No internal state other than the output registers SHALL exist; there is no state machine.

Reset
REQ-020 While rst=1: Bcomp=0, out_valid=0, err=0, applied immediately without waiting for clk.
REQ-021 An input presented on the edge at which rst is asserted SHALL be discarded; the first result after reset deassertion SHALL come from the first accepted input after deassertion.
REQ-022 Reset asserted mid-stream SHALL drop any result not yet registered; no partial output SHALL appear.

Structure
REQ-023 Shared package nines_comp_pkg SHALL hold DIGIT_W=4, BCD_MAX=9 and the per-digit complement function.
REQ-024 One sub-module, nines_digit (4-bit in, M in, 4-bit out, invalid flag out, purely combinational), SHALL be instantiated DIGITS times via a generate loop.
REQ-025 The top level SHALL contain only the generate loop, the error OR-reduction and the output registers.

Verification
REQ-026 Sweep: DIGITS=1, M=1, in_valid=1, B=0..9 on consecutive cycles -> Bcomp=9,8,...,0 one cycle later; err=0; out_valid=1 each cycle.
REQ-027 Pass-through: M=0, B=1001 -> Bcomp=1001, err=0; M=0, B=1100 -> Bcomp=1100, err=1.
REQ-028 Invalid complement: DIGITS=3, M=1, B=0x1A3 -> Bcomp=0x806, err=1.
REQ-029 Hold: accept B=0011 with M=1 (Bcomp=0110), then in_valid=0 with B=0000 for 3 cycles -> Bcomp stays 0110, out_valid=0.
REQ-030 Reset: accept B=0010 with M=1, assert rst between clock edges -> Bcomp=0, out_valid=0, err=0 immediately; after release, next accept B=0000 with M=1 -> Bcomp=1001.
REQ-031 Mode toggle: back-to-back accepts (B=0101, M=1) then (B=0101, M=0) -> Bcomp=0100, then 0101 on consecutive cycles.

Source files
------------

// File: rtl/nines_comp_pkg.sv
// Shared constants and the per-digit BCD nine's-complement function.
package nines_comp_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-BCD digits become 0 when complementing but pass through untouched otherwise.
    function automatic logic [DIGIT_W-1:0] digit_comp(input logic [DIGIT_W-1:0] d,
                                                      input logic               m);
        logic [DIGIT_W-1:0] r;
        r = d;
        if (m) begin
            if (d > BCD_MAX) begin
                r = 4'd0;
            end else begin
                r = BCD_MAX - d;
            end
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/nines_digit.sv
// Combinational single-digit slice: complement or pass-through, plus non-BCD flag.
module nines_digit
    import nines_comp_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_m,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_invalid
);

    assign o_digit   = digit_comp(i_digit, i_m);
    assign o_invalid = (i_digit > BCD_MAX);

endmodule

// File: rtl/nines_comp.sv
// DIGITS-wide BCD nine's complementer with one-cycle registered result.
module nines_comp
    import nines_comp_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  M,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   Bcomp,
    output logic                  out_valid,
    output logic                  err
);

    logic [4*DIGITS-1:0] w_comp;
    logic [DIGITS-1:0]   w_invalid;
    logic                w_err;
    logic [4*DIGITS-1:0] r_bcomp;
    logic                r_out_valid;
    logic                r_err;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        nines_digit u_digit (
            .i_digit   (B[DIGIT_W*g +: DIGIT_W]),
            .i_m       (M),
            .o_digit   (w_comp[DIGIT_W*g +: DIGIT_W]),
            .o_invalid (w_invalid[g])
        );
    end

    assign w_err = |w_invalid;

    // Output registers: capture on accept, hold result/err otherwise; valid is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcomp     <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (in_valid) begin
            r_bcomp     <= w_comp;
            r_out_valid <= 1'b1;
            r_err       <= w_err;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign Bcomp     = r_bcomp;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_nines_comp.sv
// Directed-vector bench for nines_comp at DIGITS=1 and DIGITS=3.
module tb_nines_comp;

    logic        clk;
    logic        rst;
    logic        m_s;
    logic        vld_s;
    logic [3:0]  b1_s;
    logic [11:0] b3_s;
    logic [3:0]  bc1_s;
    logic [11:0] bc3_s;
    logic        ov1_s, ov3_s, err1_s, err3_s;

    int n_checks = 0;
    int n_errors = 0;

    nines_comp #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .B(b1_s), .M(m_s), .in_valid(vld_s),
        .Bcomp(bc1_s), .out_valid(ov1_s), .err(err1_s)
    );

    nines_comp #(.DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .B(b3_s), .M(m_s), .in_valid(vld_s),
        .Bcomp(bc3_s), .out_valid(ov3_s), .err(err3_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present inputs on the falling edge, then return just after the next rising edge.
    task automatic drive(input logic [3:0] b1, input logic [11:0] b3, input logic m, input logic v);
        @(negedge clk);
        b1_s  = b1;
        b3_s  = b3;
        m_s   = m;
        vld_s = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        m_s   = 1'b0;
        vld_s = 1'b0;
        b1_s  = 4'd0;
        b3_s  = 12'h000;
        #3;
        check("rst_bcomp", 32'(bc1_s), 32'h0);
        check("rst_ovalid", 32'(ov1_s), 32'h0);
        check("rst_err", 32'(err1_s), 32'h0);

        // Input offered while reset is held must be discarded.
        drive(4'd5, 12'hABC, 1'b1, 1'b1);
        check("rst_discard_bcomp", 32'(bc1_s), 32'h0);
        check("rst_discard_ovalid", 32'(ov1_s), 32'h0);
        check("rst_discard_err3", 32'(err3_s), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        vld_s = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(4'(i), 12'h000, 1'b1, 1'b1);
            check($sformatf("sweep_bcomp_%0d", i), 32'(bc1_s), 32'(9 - i));
            check($sformatf("sweep_ovalid_%0d", i), 32'(ov1_s), 32'h1);
            check($sformatf("sweep_err_%0d", i), 32'(err1_s), 32'h0);
        end

        drive(4'b1001, 12'h1A3, 1'b0, 1'b1);
        check("pass_1001_bcomp", 32'(bc1_s), 32'h9);
        check("pass_1001_err", 32'(err1_s), 32'h0);
        check("pass_1A3_d3", 32'(bc3_s), 32'h1A3);
        check("pass_1A3_err3", 32'(err3_s), 32'h1);

        drive(4'b1100, 12'h1A3, 1'b1, 1'b1);
        check("inv_comp_d1", 32'(bc1_s), 32'h0);
        check("inv_comp_err1", 32'(err1_s), 32'h1);
        check("inv_comp_d3", 32'(bc3_s), 32'h806);
        check("inv_comp_err3", 32'(err3_s), 32'h1);

        drive(4'b1100, 12'h000, 1'b0, 1'b1);
        check("pass_1100_bcomp", 32'(bc1_s), 32'hC);
        check("pass_1100_err", 32'(err1_s), 32'h1);
        check("comp_000_d3", 32'(bc3_s), 32'h000);
        check("comp_000_err3", 32'(err3_s), 32'h0);

        drive(4'b0011, 12'h024, 1'b1, 1'b1);
        check("hold_accept_bcomp", 32'(bc1_s), 32'h6);
        check("hold_accept_err", 32'(err1_s), 32'h0);
        check("comp_024_d3", 32'(bc3_s), 32'h975);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 12'hFFF, 1'b1, 1'b0);
            check($sformatf("hold_bcomp_%0d", i), 32'(bc1_s), 32'h6);
            check($sformatf("hold_ovalid_%0d", i), 32'(ov1_s), 32'h0);
            check($sformatf("hold_err3_%0d", i), 32'(err3_s), 32'h0);
        end

        drive(4'b0010, 12'h000, 1'b1, 1'b1);
        check("pre_rst_bcomp", 32'(bc1_s), 32'h7);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_bcomp", 32'(bc1_s), 32'h0);
        check("async_rst_ovalid", 32'(ov1_s), 32'h0);
        check("async_rst_err", 32'(err1_s), 32'h0);
        check("async_rst_d3", 32'(bc3_s), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        vld_s = 1'b0;
        drive(4'b0000, 12'h000, 1'b1, 1'b1);
        check("post_rst_bcomp", 32'(bc1_s), 32'h9);
        check("post_rst_ovalid", 32'(ov1_s), 32'h1);

        drive(4'b0101, 12'h000, 1'b1, 1'b1);
        check("toggle_m1_bcomp", 32'(bc1_s), 32'h4);
        drive(4'b0101, 12'h000, 1'b0, 1'b1);
        check("toggle_m0_bcomp", 32'(bc1_s), 32'h5);
        check("toggle_m0_ovalid", 32'(ov1_s), 32'h1);

        drive(4'b0000, 12'h000, 1'b0, 1'b0);
        check("idle_ovalid", 32'(ov1_s), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
